// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit results into one register-file
// write port, MEM-first with a bounded starvation guard for the ALU.
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [31:0] pending_mask
);

    localparam int unsigned CW =
        (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          open;
    logic          grant_alu;
    logic          grant_mem;
    logic          xfer;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;

    assign starved = (starve_cnt == LIMIT);

    // Reset gates the grants so nothing is accepted while rst_n is low.
    assign open = rst_n && !stall;

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (open) begin
            grant_alu = alu_valid && (!mem_valid || starved);
            grant_mem = mem_valid && !grant_alu;
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign xfer      = grant_alu || grant_mem;
    assign sel_rd    = grant_alu ? alu_rd : mem_rd;
    assign sel_data  = grant_alu ? alu_data : mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (stall) begin
            starve_cnt <= starve_cnt;
        end else if (!alu_valid || grant_alu) begin
            starve_cnt <= '0;
        end else if (grant_mem && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // x0 writes are accepted but dropped here, leaving address/data as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we      <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            we <= xfer && (sel_rd != 5'd0);
            if (xfer && (sel_rd != 5'd0)) begin
                rd_addr <= sel_rd;
                rd_data <= sel_data;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        if (we) begin
            pending_mask[rd_addr] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grants, starvation, stall, x0 drop, reset.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] pending_mask;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .we           (we),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pending_mask (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // {alu_ready, mem_ready} as a 2-bit code: 2 = ALU, 1 = MEM, 0 = none
    function automatic logic [31:0] rdy();
        return {30'd0, alu_ready, mem_ready};
    endfunction

    // grant pattern with both valid from a cleared counter
    logic [1:0] pat [8] = '{2'd1, 2'd1, 2'd1, 2'd2,
                            2'd1, 2'd1, 2'd1, 2'd2};

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h1111_1111;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_data  = 32'h0;

        // reset state, ready gated during reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_addr", {27'd0, rd_addr}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_mask", pending_mask, 32'd0);
        chk("rst_rdy", rdy(), 32'd0);

        // single ALU write to x5
        @(negedge clk);
        rst_n     = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        #1;
        chk("alu_rdy", rdy(), 32'd2);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("alu_we", {31'd0, we}, 32'd1);
        chk("alu_addr", {27'd0, rd_addr}, 32'd5);
        chk("alu_data", rd_data, 32'hDEAD_BEEF);
        chk("alu_mask", pending_mask, 32'h0000_0020);
        @(negedge clk);
        #1;
        chk("idle_we", {31'd0, we}, 32'd0);
        chk("idle_addr", {27'd0, rd_addr}, 32'd5);
        chk("idle_mask", pending_mask, 32'd0);

        // both valid: MEM x1, ALU x2
        @(negedge clk);
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        alu_data  = 32'hA0A0_A0A0;
        mem_valid = 1'b1;
        mem_rd    = 5'd1;
        mem_data  = 32'h5050_5050;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("starve_g%0d", k), rdy(), {30'd0, pat[k]});
            if (k > 0)
                chk($sformatf("starve_a%0d", k), {27'd0, rd_addr},
                    (pat[k-1] == 2'd2) ? 32'd2 : 32'd1);
            @(negedge clk);
        end

        // two MEM grants bring the counter to 2, then stall 4 cycles
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("pre_g%0d", k), rdy(), 32'd1);
            @(negedge clk);
        end
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("stall_g%0d", k), rdy(), 32'd0);
            chk($sformatf("stall_we%0d", k), {31'd0, we},
                (k == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        chk("resume_g0", rdy(), 32'd1);
        @(negedge clk);
        #1;
        chk("resume_g1", rdy(), 32'd2);
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("resume_addr", {27'd0, rd_addr}, 32'd2);

        // MEM write to x0 is accepted and dropped
        @(negedge clk);
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        mem_data  = 32'h1234_5678;
        #1;
        chk("x0_rdy", rdy(), 32'd1);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        chk("x0_we", {31'd0, we}, 32'd0);
        chk("x0_mask", pending_mask, 32'd0);

        // back-to-back writes to x3, MEM then ALU
        @(negedge clk);
        mem_valid = 1'b1;
        mem_rd    = 5'd3;
        mem_data  = 32'd1;
        #1;
        chk("b2b_rdy0", rdy(), 32'd1);
        @(negedge clk);
        mem_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'd2;
        #1;
        chk("b2b_rdy1", rdy(), 32'd2);
        chk("b2b_we0", {31'd0, we}, 32'd1);
        chk("b2b_data0", rd_data, 32'd1);
        chk("b2b_mask0", pending_mask, 32'h0000_0008);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("b2b_we1", {31'd0, we}, 32'd1);
        chk("b2b_addr1", {27'd0, rd_addr}, 32'd3);
        chk("b2b_data1", rd_data, 32'd2);

        // async reset while x7 write sits in the output stage
        @(negedge clk);
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 32'h7777_7777;
        @(negedge clk);
        #1;
        chk("pre_rst_we", {31'd0, we}, 32'd1);
        chk("pre_rst_addr", {27'd0, rd_addr}, 32'd7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_we", {31'd0, we}, 32'd0);
        chk("arst_addr", {27'd0, rd_addr}, 32'd0);
        chk("arst_data", rd_data, 32'd0);
        chk("arst_mask", pending_mask, 32'd0);
        chk("arst_rdy", rdy(), 32'd0);

        // first grant on the first edge after release
        @(negedge clk);
        rst_n    = 1'b1;
        alu_rd   = 5'd4;
        alu_data = 32'hCAFE_F00D;
        #1;
        chk("rel_rdy", rdy(), 32'd2);
        chk("rel_we", {31'd0, we}, 32'd0);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("rel_addr", {27'd0, rd_addr}, 32'd4);
        chk("rel_data", rd_data, 32'hCAFE_F00D);
        chk("rel_mask", pending_mask, 32'h0000_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: max consecutive cycles the ALU requester may be denied while MEM is granted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  when 1, no new grant is issued this cycle.
REQ-005 alu_valid  input  1  ALU writeback request present.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU writeback value.
REQ-008 alu_ready  output  1  ALU request accepted this cycle (combinational).
REQ-009 mem_valid  input  1  load-unit writeback request present.
REQ-010 mem_rd  input  5  load destination register.
REQ-011 mem_data  input  32  load writeback value.
REQ-012 mem_ready  output  1  MEM request accepted this cycle (combinational).
REQ-013 we  output  1  registered write enable to the register file.
REQ-014 rd_addr  output  5  registered write address to the register file.
REQ-015 rd_data  output  32  registered write data to the register file.
REQ-016 pending_mask  output  32  bit i = 1 while a write to xi sits in the output stage.

Function
REQ-017 Handshake: transfer occurs on a cycle where valid and ready are both 1; requester holds valid, rd, data stable until accepted.
REQ-018 At most one of alu_ready, mem_ready is 1 in any cycle.
REQ-019 ready depends only on valid inputs, stall and internal state; never on ready.
REQ-020 stall = 1: alu_ready = mem_ready = 0; starvation counter holds.
REQ-021 Default priority: MEM over ALU when both valid.
REQ-022 Starvation counter (width clog2(STARVE_LIMIT+1)): increments each cycle MEM is granted while alu_valid = 1; saturates at STARVE_LIMIT.
REQ-023 Counter = STARVE_LIMIT and both valid and stall = 0: ALU granted, MEM denied, counter cleared.
REQ-024 Counter clears on any ALU grant and on any cycle alu_valid = 0.
REQ-025 Only one valid: that requester granted (if stall = 0); counter rules still apply.
REQ-026 Latency: transfer at edge N is presented on we/rd_addr/rd_data during cycle N+1 (one register stage).
REQ-027 No transfer at edge N: we = 0 in cycle N+1; rd_addr/rd_data hold previous values.
REQ-028 Transfer with rd = 0: accepted normally, we = 0 in cycle N+1, pending_mask unchanged (x0 writes discarded).
REQ-029 pending_mask = (we ? one-hot(rd_addr) : 0), derived from output-stage registers only; bit 0 always 0.
REQ-030 Output stage never back-pressures: register file accepts every write, so a grant is possible every cycle; sustained throughput one write per cycle.
REQ-031 Same rd from both requesters on consecutive cycles: both writes issued in grant order; last granted value persists.

Reset
REQ-032 rst_n low asynchronously forces we = 0, rd_addr = 0, rd_data = 0, counter = 0, pending_mask = 0.
REQ-033 While rst_n = 0: alu_ready = mem_ready = 0.
REQ-034 Reset asserted mid-transfer: in-flight output-stage write discarded; requesters must re-present after release.
REQ-035 First grant possible on the first rising edge with rst_n = 1.

Verification
REQ-036 ALU only, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 at N; cycle N+1 we=1, rd_addr=5, rd_data=0xDEADBEEF, pending_mask=0x00000020.
REQ-037 Both valid continuously, STARVE_LIMIT=3 -> grant sequence MEM,MEM,MEM,ALU,MEM,MEM,MEM,ALU...; never both ready.
REQ-038 MEM request rd=0, data=0x12345678 -> mem_ready=1; cycle N+1 we=0, pending_mask=0.
REQ-039 stall=1 for 4 cycles with both valid -> no ready, we=0 from second cycle, counter unchanged; release -> grant resumes per counter state.
REQ-040 Reset pulse while we=1 rd_addr=7 -> we=0, rd_addr=0, rd_data=0, pending_mask=0 immediately, before next clock edge.
REQ-041 Back-to-back MEM rd=3 data=1 then ALU rd=3 data=2 -> two consecutive writes to x3; final register value 2.
